// File: rtl/bram_flush_ctrl.sv
// BRAM initialise/flush engine: owns NUM_CH write ports while writing a fill value to every address,
// otherwise forwards user writes through one register stage. Optional macro: BRAM_FLUSH_CUSTOM_VALUE_EN.
module bram_flush_ctrl #(
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DATA_WIDTH = 36,
  parameter int                    NUM_CH     = 2,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = {DATA_WIDTH{1'b1}}
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush_start,
  input  logic                         flush_abort,
  input  logic [NUM_CH-1:0]            ch_mask,
`ifdef BRAM_FLUSH_CUSTOM_VALUE_EN
  input  logic [DATA_WIDTH-1:0]        fill_data,
`endif
  input  logic [ADDR_WIDTH-1:0]        usr_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] usr_wdata,
  input  logic [NUM_CH-1:0]            usr_wen,
  output logic [ADDR_WIDTH-1:0]        bram_addr,
  output logic [NUM_CH*DATA_WIDTH-1:0] bram_wdata,
  output logic [NUM_CH-1:0]            bram_wen,
  output logic                         busy,
  output logic                         done,
  output logic                         usr_drop
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                      state_reg, state_next;
  logic [ADDR_WIDTH-1:0]       cnt_reg, cnt_next;
  logic [NUM_CH-1:0]           mask_reg, mask_next;
  logic [DATA_WIDTH-1:0]       fill_reg, fill_next;

  logic [ADDR_WIDTH-1:0]        addr_reg, addr_next;
  logic [NUM_CH*DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [NUM_CH-1:0]            wen_reg, wen_next;
  logic                         busy_reg, busy_next;
  logic                         done_reg, done_next;
  logic                         drop_reg, drop_next;

  logic [DATA_WIDTH-1:0]        fill_src;
  logic [DATA_WIDTH-1:0]        fill_word;
  logic [NUM_CH*DATA_WIDTH-1:0] fill_bus;

`ifdef BRAM_FLUSH_CUSTOM_VALUE_EN
  assign fill_src = fill_data;
`else
  assign fill_src = FILL_VALUE;
`endif

  // The first flush write leaves in the start cycle, before fill_reg has been loaded.
  assign fill_word = (state_reg == IDLE) ? fill_src : fill_reg;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_fill
      assign fill_bus[gi*DATA_WIDTH +: DATA_WIDTH] = fill_word;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mask_next  = mask_reg;
    fill_next  = fill_reg;
    addr_next  = '0;
    wdata_next = '0;
    wen_next   = '0;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    drop_next  = drop_reg | (busy_reg & (|usr_wen));

    case (state_reg)
      IDLE: begin
        if (flush_start && !flush_abort) begin
          drop_next = 1'b0;
          mask_next = ch_mask;
          fill_next = fill_src;
          cnt_next  = '0;
          if (ch_mask == '0) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            state_next = FLUSH;
            wdata_next = fill_bus;
            wen_next   = ch_mask;
            busy_next  = 1'b1;
          end
        end else begin
          addr_next  = usr_addr;
          wdata_next = usr_wdata;
          wen_next   = usr_wen;
        end
      end

      FLUSH: begin
        // Abort outranks completion, so an abort on the last address yields no done.
        if (flush_abort) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == LAST_ADDR) begin
          state_next = DONE;
          done_next  = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt_reg + 1'b1;
          addr_next  = cnt_reg + 1'b1;
          wdata_next = fill_bus;
          wen_next   = mask_reg;
          busy_next  = 1'b1;
        end
      end

      DONE: begin
        state_next = IDLE;
        addr_next  = usr_addr;
        wdata_next = usr_wdata;
        wen_next   = usr_wen;
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      mask_reg  <= '0;
      fill_reg  <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wen_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      drop_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      mask_reg  <= mask_next;
      fill_reg  <= fill_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      wen_reg   <= wen_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      drop_reg  <= drop_next;
    end
  end

  assign bram_addr  = addr_reg;
  assign bram_wdata = wdata_reg;
  assign bram_wen   = wen_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign usr_drop   = drop_reg;

endmodule

// File: tb/tb_bram_flush_ctrl.sv
// Scoreboard bench for bram_flush_ctrl: a transaction-level model expands each accepted flush
// into its full write plan; a negedge monitor pops one expected output word per clock.
`timescale 1ns/1ps
module tb_bram_flush_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NCH = 2;
  localparam logic [DW-1:0] FILL = 8'hFF;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                flush_start = 1'b0;
  logic                flush_abort = 1'b0;
  logic [NCH-1:0]      ch_mask = '0;
  logic [DW-1:0]       fill_data = '0;
  logic [AW-1:0]       usr_addr = '0;
  logic [NCH*DW-1:0]   usr_wdata = '0;
  logic [NCH-1:0]      usr_wen = '0;
  logic [AW-1:0]       bram_addr;
  logic [NCH*DW-1:0]   bram_wdata;
  logic [NCH-1:0]      bram_wen;
  logic                busy, done, usr_drop;

  bram_flush_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NCH), .FILL_VALUE(FILL)) dut (
    .clk(clk), .reset(reset), .flush_start(flush_start), .flush_abort(flush_abort),
    .ch_mask(ch_mask),
`ifdef BRAM_FLUSH_CUSTOM_VALUE_EN
    .fill_data(fill_data),
`endif
    .usr_addr(usr_addr), .usr_wdata(usr_wdata), .usr_wen(usr_wen),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_wen(bram_wen),
    .busy(busy), .done(done), .usr_drop(usr_drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]     addr;
    logic [NCH*DW-1:0] wdata;
    logic [NCH-1:0]    wen;
    logic              busy;
    logic              done;
    logic              drop;
  } exp_t;

  exp_t sb_q[$];
  int   sb_cyc[$];
  exp_t plan[$];
  exp_t cur = '0;
  logic drop_m = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: one expected output word per clock, matched by target cycle.
  always @(negedge clk) begin : mon
    exp_t e, a;
    int   c;
    if (sb_q.size() != 0 && sb_cyc[0] <= cyc) begin
      e = sb_q.pop_front();
      c = sb_cyc.pop_front();
      a = {bram_addr, bram_wdata, bram_wen, busy, done, usr_drop};
      n_chk++;
      if (c != cyc)
        $display("FAIL sb_late cyc=%0d got_check_at=%0d required_at=%0d", cyc, cyc, c);
      else if (a !== e)
        $display("FAIL sb cyc=%0d got addr=%h wdata=%h wen=%b busy=%b done=%b drop=%b required addr=%h wdata=%h wen=%b busy=%b done=%b drop=%b",
                 cyc, a.addr, a.wdata, a.wen, a.busy, a.done, a.drop,
                 e.addr, e.wdata, e.wen, e.busy, e.done, e.drop);
      else begin
        n_pass++;
        if (e.done)
          $display("cyc %0d: flush done", cyc);
        else if (!e.busy && e.wen != '0)
          $display("cyc %0d: user write addr=%h wdata=%h wen=%b", cyc, e.addr, e.wdata, e.wen);
      end
    end
  end

  // Applies one cycle of stimulus and pushes the output expected after the next edge.
  task automatic step(input logic st, input logic ab, input logic [NCH-1:0] m,
                      input logic [AW-1:0] ua, input logic [NCH*DW-1:0] ud,
                      input logic [NCH-1:0] uw, input logic [DW-1:0] fd);
    exp_t nx;
    logic [DW-1:0] fv;
    flush_start = st; flush_abort = ab; ch_mask = m;
    usr_addr = ua; usr_wdata = ud; usr_wen = uw; fill_data = fd;
    if (cur.busy && uw != '0) drop_m = 1'b1;
    if (plan.size() != 0) begin
      if (ab) begin
        plan.delete();
        nx = '0;
      end else begin
        nx = plan.pop_front();
      end
    end else if (st && !ab && !cur.done) begin
      drop_m = 1'b0;
`ifdef BRAM_FLUSH_CUSTOM_VALUE_EN
      fv = fd;
`else
      fv = FILL;
`endif
      if (m != '0)
        for (int a = 0; a < (1 << AW); a++) begin
          nx = '0;
          nx.addr = a[AW-1:0];
          nx.wdata = {NCH{fv}};
          nx.wen = m;
          nx.busy = 1'b1;
          plan.push_back(nx);
        end
      nx = '0;
      nx.done = 1'b1;
      plan.push_back(nx);
      nx = plan.pop_front();
    end else begin
      nx = '0;
      nx.addr = ua;
      nx.wdata = ud;
      nx.wen = uw;
    end
    nx.drop = drop_m;
    sb_q.push_back(nx);
    sb_cyc.push_back(cyc + 1);
    cur = nx;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic st, input logic ab, input logic [NCH-1:0] m, input logic [NCH-1:0] uw);
    logic [31:0] r1, r2;
    r1 = $urandom;
    r2 = $urandom;
    step(st, ab, m, r1[AW-1:0], r1[31:32-NCH*DW], uw, r2[DW-1:0]);
  endtask

  task automatic run_until_done();
    for (int i = 0; i < 100 && !cur.done; i++) go(1'b0, 1'b0, '0, '0);
  endtask

  task automatic check_zero(input string tag);
    n_chk++;
    if ({bram_addr, bram_wdata, bram_wen, busy, done, usr_drop} !== '0)
      $display("FAIL %s got addr=%h wdata=%h wen=%b busy=%b done=%b drop=%b required all zero",
               tag, bram_addr, bram_wdata, bram_wen, busy, done, usr_drop);
    else
      n_pass++;
  endtask

  // Asynchronous reset between edges; outputs must clear without waiting for a clock.
  task automatic async_reset(input string tag);
    reset = 1'b1;
    flush_start = 1'b0; flush_abort = 1'b0; usr_wen = '0;
    sb_q.delete(); sb_cyc.delete(); plan.delete();
    cur = '0; drop_m = 1'b0;
    #2;
    check_zero(tag);
    @(posedge clk);
    #1;
    check_zero({tag, "_held"});
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got no finish required finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    reset = 1'b0;

    // Full flush, all channels
    repeat (6) go(1'b0, 1'b0, '0, '0);
    go(1'b1, 1'b0, 2'b11, '0);
    run_until_done();
    repeat (2) go(1'b0, 1'b0, '0, '0);

    // Single channel, then empty mask
    go(1'b1, 1'b0, 2'b01, '0);
    run_until_done();
    go(1'b0, 1'b0, '0, '0);
    go(1'b1, 1'b0, 2'b00, '0);
    repeat (3) go(1'b0, 1'b0, '0, '0);

    // Abort at address 5, then restart from 0
    go(1'b1, 1'b0, 2'b11, '0);
    for (int i = 0; i < 40 && !(cur.busy && cur.addr == 4'd5); i++) go(1'b0, 1'b0, '0, '0);
    go(1'b0, 1'b1, '0, '0);
    repeat (3) go(1'b0, 1'b0, '0, '0);
    go(1'b1, 1'b0, 2'b10, '0);
    run_until_done();

    // Passthrough, then the same write while busy is dropped and sticky
    step(1'b0, 1'b0, '0, 4'h3, 16'hA55A, 2'b10, 8'h00);
    go(1'b0, 1'b0, '0, '0);
    go(1'b1, 1'b0, 2'b11, '0);
    repeat (3) go(1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, 4'h3, 16'hA55A, 2'b10, 8'h00);
    run_until_done();
    repeat (4) go(1'b0, 1'b0, '0, 2'b01);
    go(1'b1, 1'b1, 2'b11, '0);
    repeat (2) go(1'b0, 1'b0, '0, '0);

    // Start during flush and during the done cycle are ignored
    go(1'b1, 1'b0, 2'b11, '0);
    repeat (5) go(1'b1, 1'b0, 2'b01, '0);
    for (int i = 0; i < 40 && !cur.done; i++) go(1'b0, 1'b0, '0, '0);
    go(1'b1, 1'b0, 2'b11, '0);
    repeat (2) go(1'b0, 1'b0, '0, '0);

    // Reset at flush address 7, with an explicit 8'h3C fill word
    step(1'b1, 1'b0, 2'b11, 4'h0, 16'h0000, 2'b00, 8'h3C);
    for (int i = 0; i < 40 && !(cur.busy && cur.addr == 4'd7); i++) go(1'b0, 1'b0, '0, '0);
    async_reset("reset_mid_flush");
    repeat (3) go(1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 2'b11, 4'h0, 16'h0000, 2'b00, 8'h3C);
    run_until_done();

    // Randomized traffic
    for (int i = 0; i < 700; i++) begin
      logic [31:0] r;
      r = $urandom;
      go(r[4:0] == 5'd0, r[10:5] == 6'd0, r[12:11], (r[13] ? r[15:14] : 2'b00));
    end
    repeat (20) go(1'b0, 1'b1, '0, '0);

    repeat (3) @(posedge clk);
    n_chk++;
    if (sb_q.size() != 0)
      $display("FAIL sb_drain got %0d pending required 0", sb_q.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bram_flush_ctrl.md
Name: bram_flush_ctrl

Overview:
- Parametrised BRAM initialise/flush engine.
- Generalises the constant-one tie-off used in the bram flush_opt mode into a sequencer that writes a fill value to every address of NUM_CH BRAM write ports.
- Sits between user logic and the BRAM write ports of the bram logical tile.
- Owns the write ports while flushing; otherwise forwards user writes through a registered stage.

Parameters:
- ADDR_WIDTH, 10: BRAM address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 36: write data width per channel.
- NUM_CH, 2: number of BRAM channels (write ports) controlled.
- FILL_VALUE, all ones ({DATA_WIDTH{1'b1}}): constant written during flush.

Ports:
- clk  input  1  single clock.
- reset  input  1  asynchronous, active-high reset.
- flush_start  input  1  one-cycle request to begin a flush.
- flush_abort  input  1  terminate the current flush.
- ch_mask  input  NUM_CH  channels to flush; sampled at the accepted start.
- usr_addr  input  ADDR_WIDTH  user write address.
- usr_wdata  input  NUM_CH*DATA_WIDTH  user write data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- usr_wen  input  NUM_CH  user per-channel write enables.
- bram_addr  output  ADDR_WIDTH  write address to the BRAM.
- bram_wdata  output  NUM_CH*DATA_WIDTH  write data to the BRAM.
- bram_wen  output  NUM_CH  per-channel write enables.
- busy  output  1  flush in progress; user writes are dropped while high.
- done  output  1  one-cycle pulse when a flush completes normally.
- usr_drop  output  1  sticky; a user write was dropped during busy.

Behaviour:
- Reset: all outputs are 0 (bram_addr, bram_wdata, bram_wen, busy, done, usr_drop). FSM goes to IDLE and the address counter clears. All outputs are registered.
- FSM states:
  - IDLE: outputs follow usr_* with 1-cycle latency; busy = 0.
  - FLUSH: one write per cycle.
  - DONE: a single cycle, then back to IDLE.
- IDLE -> FLUSH: on flush_start=1 with flush_abort=0.
  - If ch_mask==0, go to DONE directly; done pulses with no writes.
  - On the cycle after start: busy=1, bram_addr=0, bram_wen=latched mask, bram_wdata=fill value on every channel.
- FLUSH:
  - Address increments by 1 each cycle, from 0 to 2**ADDR_WIDTH-1.
  - After the write at the last address, next state is DONE. The counter does not wrap into a second pass.
- DONE: busy=0, bram_wen=0, done=1 for exactly one cycle, then IDLE.
  - First flush write is visible at cycle N+1 (N = start cycle).
  - done is high at cycle N+1+2**ADDR_WIDTH.
- flush_abort in FLUSH: next cycle goes to IDLE with bram_wen=0, busy=0 and no done pulse. Addresses already written stay written.
- Simultaneous events:
  - flush_start and flush_abort both high in IDLE: abort wins and start is ignored.
  - flush_start while FLUSH or DONE: ignored; no restart, no queueing.
- User writes while busy: any usr_wen bit high sets usr_drop. usr_drop clears only on reset or on an accepted flush_start.
- In the IDLE passthrough, bram_wen bits are forwarded regardless of ch_mask.
- Reset asserted mid-flush: immediate return to reset values; no done.

Optional Feature:
- Macro BRAM_FLUSH_CUSTOM_VALUE_EN.
- When defined:
  - Adds input port fill_data (DATA_WIDTH), sampled together with ch_mask at the accepted start and used as the fill value for the whole flush.
  - fill_data changes mid-flush have no effect.
- When undefined: the port does not exist and FILL_VALUE is used.

Test Plan (ADDR_WIDTH=4, DATA_WIDTH=8, NUM_CH=2, FILL_VALUE=8'hFF):
- Reset release then flush_start with ch_mask=2'b11 at cycle 10:
  - cycles 11..26: bram_addr 0..15, bram_wen=2'b11, bram_wdata=16'hFFFF, busy=1.
  - cycle 27: done=1, busy=0.
  - cycle 28: done=0.
- Flush with ch_mask=2'b01 -> bram_wen=2'b01 for 16 cycles. Then ch_mask=2'b00 -> done pulses one cycle after start with zero writes.
- flush_abort at the 6th flush cycle (bram_addr=5):
  - next cycle: busy=0, bram_wen=0.
  - done never asserts.
  - a new flush_start afterwards restarts from address 0.
- IDLE passthrough: usr_addr=4'h3, usr_wdata=16'hA55A, usr_wen=2'b10 -> next cycle bram_* carries exactly those values. The same write during busy -> not forwarded, usr_drop=1, stays 1 until the next accepted start.
- Simultaneous events:
  - flush_start with flush_abort in IDLE -> busy stays 0.
  - flush_start during FLUSH -> the sequence is unaltered and done occurs at the original cycle.
- Reset pulse at flush address 7 -> all outputs 0 asynchronously, no done; with BRAM_FLUSH_CUSTOM_VALUE_EN, fill_data=8'h3C gives bram_wdata=16'h3C3C throughout the flush.
